// File: rtl/id_stage_ctrl_pkg.sv
// Shared decode definitions for the instruction-decode stage controller:
// opcode constants, immediate-format encodings and the stage state enum.
package id_stage_ctrl_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_J    = 3'b011,
        IMM_U    = 3'b100,
        IMM_NONE = 3'b111
    } imm_type_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_FULL   = 2'b01,
        ST_BUBBLE = 2'b10
    } id_state_t;

    // S and B formats carry immediate bits where rd would sit.
    function automatic logic writes_rd(input imm_type_t t);
        return !((t == IMM_S) || (t == IMM_B));
    endfunction

endpackage

// File: rtl/id_stage_ctrl_if.sv
// Fetch/decode/execute handshake bundle for id_stage_ctrl.
// master = surrounding pipeline, slave = the decode stage.
interface id_stage_ctrl_if;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        ex_ready;
    logic        flush;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [24:0] id_imm_val;
    logic [2:0]  id_imm_type;
    logic        id_illegal;

    modport master (
        output if_valid, if_instr, if_pc, ex_ready, flush, ex_valid, ex_is_load, ex_rd,
        input  if_ready, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm_val, id_imm_type, id_illegal
    );

    modport slave (
        input  if_valid, if_instr, if_pc, ex_ready, flush, ex_valid, ex_is_load, ex_rd,
        output if_ready, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm_val, id_imm_type, id_illegal
    );
endinterface

// File: rtl/id_format_decode.sv
// Combinational opcode-to-format decode for the decode stage.
// Illegal-opcode detection exists only when ID_ILLEGAL_TRAP_EN is defined.
module id_format_decode
    import id_stage_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output imm_type_t  imm_type,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       illegal
);

    // Immediate format and source-register usage per opcode.
    always_comb begin
        imm_type = IMM_NONE;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                imm_type = IMM_I;
                uses_rs1 = 1'b1;
            end
            OPC_STORE: begin
                imm_type = IMM_S;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_JAL: begin
                imm_type = IMM_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_type = IMM_U;
            end
            OPC_OP: begin
                imm_type = IMM_NONE;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: begin
                imm_type = IMM_NONE;
            end
        endcase
    end

`ifdef ID_ILLEGAL_TRAP_EN
    // Any opcode outside the recognised set is flagged.
    always_comb begin
        illegal = 1'b1;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_OP: illegal = 1'b0;
            default: illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: one-entry instruction register with load-use bubble,
// flush and backpressure. ID_ILLEGAL_TRAP_EN enables illegal-opcode flagging.
module id_stage_ctrl
    import id_stage_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    id_stage_ctrl_if.slave bus
);

    id_state_t   state_r;
    id_state_t   state_nxt_s;
    logic [31:0] instr_r;
    logic [31:0] pc_r;

    imm_type_t   imm_type_s;
    logic        uses_rs1_s;
    logic        uses_rs2_s;
    logic        fmt_illegal_s;
    logic        hazard_s;
    logic        id_valid_s;
    logic        if_ready_s;
    logic        up_s;
    logic        down_s;

    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;

    assign rs1_s = instr_r[19:15];
    assign rs2_s = instr_r[24:20];

    id_format_decode u_fmt (
        .opcode   (instr_r[6:0]),
        .imm_type (imm_type_s),
        .uses_rs1 (uses_rs1_s),
        .uses_rs2 (uses_rs2_s),
        .illegal  (fmt_illegal_s)
    );

    // Load-use: the held instruction reads the register a load in execute writes.
    assign hazard_s = (state_r == ST_FULL) && bus.ex_valid && bus.ex_is_load &&
                      (bus.ex_rd != 5'd0) &&
                      ((uses_rs1_s && (rs1_s == bus.ex_rd)) ||
                       (uses_rs2_s && (rs2_s == bus.ex_rd)));

    assign up_s   = bus.if_valid && if_ready_s;
    assign down_s = id_valid_s && bus.ex_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush overrides every transfer.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (up_s) state_nxt_s = ST_FULL;
                    else      state_nxt_s = ST_EMPTY;
                end
                ST_FULL: begin
                    if (hazard_s)             state_nxt_s = ST_BUBBLE;
                    else if (down_s && up_s)  state_nxt_s = ST_FULL;
                    else if (down_s)          state_nxt_s = ST_EMPTY;
                    else                      state_nxt_s = ST_FULL;
                end
                ST_BUBBLE: state_nxt_s = ST_FULL;
                default:   state_nxt_s = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs; if_ready deliberately ignores if_valid.
    always_comb begin
        id_valid_s = 1'b0;
        if_ready_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                id_valid_s = 1'b0;
                if_ready_s = !bus.flush;
            end
            ST_FULL: begin
                id_valid_s = !hazard_s;
                if_ready_s = !bus.flush && bus.ex_ready && !hazard_s;
            end
            ST_BUBBLE: begin
                id_valid_s = 1'b0;
                if_ready_s = 1'b0;
            end
            default: begin
                id_valid_s = 1'b0;
                if_ready_s = 1'b0;
            end
        endcase
    end

    // Instruction register: cleared on flush so a dropped instruction leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r <= 32'd0;
            pc_r    <= 32'd0;
        end else if (bus.flush) begin
            instr_r <= 32'd0;
            pc_r    <= 32'd0;
        end else if (up_s) begin
            instr_r <= bus.if_instr;
            pc_r    <= bus.if_pc;
        end else begin
            instr_r <= instr_r;
            pc_r    <= pc_r;
        end
    end

    assign bus.if_ready    = if_ready_s;
    assign bus.id_valid    = id_valid_s;
    assign bus.id_pc       = pc_r;
    assign bus.id_rs1      = rs1_s;
    assign bus.id_rs2      = rs2_s;
    assign bus.id_rd       = writes_rd(imm_type_s) ? instr_r[11:7] : 5'd0;
    assign bus.id_imm_val  = instr_r[31:7];
    assign bus.id_imm_type = imm_type_s;

`ifdef ID_ILLEGAL_TRAP_EN
    assign bus.id_illegal  = (state_r == ST_FULL) && fmt_illegal_s;
`else
    // The decoder drives this low when illegal detection is compiled out.
    assign bus.id_illegal  = fmt_illegal_s;
`endif

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Self-checking bench for id_stage_ctrl: directed scenarios followed by random
// traffic, all outputs compared each cycle against a behavioural model.
module tb_id_stage_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_ctrl_if bus ();

    id_stage_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: occupancy (0 empty, 1 holding, 2 holding but in its bubble) and contents.
    int          m_mode;
    logic [31:0] m_instr;
    logic [31:0] m_pc;

    function automatic byte fmt_of(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        case (op)
            7'h13, 7'h03, 7'h67: return "I";
            7'h23:               return "S";
            7'h63:               return "B";
            7'h6F:               return "J";
            7'h37, 7'h17:        return "U";
            7'h33:               return "R";
            default:             return "X";
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic er, input logic ev, input logic ld,
                         input logic [4:0] rd, input logic fl);
        bus.if_valid   = v;
        bus.if_instr   = i;
        bus.if_pc      = p;
        bus.ex_ready   = er;
        bus.ex_valid   = ev;
        bus.ex_is_load = ld;
        bus.ex_rd      = rd;
        bus.flush      = fl;
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_instr = 32'd0;
        m_pc    = 32'd0;
    endtask

    // One cycle: check outputs against the model, clock, then advance the model.
    task automatic step(input string tag);
        byte         f;
        logic        r1, r2, haz, ev, er, ill;
        logic [2:0]  it;
        logic [4:0]  rd;
        #3;
        f   = fmt_of(m_instr);
        r1  = (f == "R") || (f == "I") || (f == "S") || (f == "B");
        r2  = (f == "R") || (f == "S") || (f == "B");
        haz = (m_mode == 1) && bus.ex_valid && bus.ex_is_load && (bus.ex_rd != 5'd0) &&
              ((r1 && (m_instr[19:15] == bus.ex_rd)) || (r2 && (m_instr[24:20] == bus.ex_rd)));
        ev  = (m_mode == 1) && !haz;
        er  = !bus.flush && ((m_mode == 0) || ((m_mode == 1) && bus.ex_ready && !haz));
        case (f)
            "I":     it = 3'b000;
            "S":     it = 3'b001;
            "B":     it = 3'b010;
            "J":     it = 3'b011;
            "U":     it = 3'b100;
            default: it = 3'b111;
        endcase
        rd = ((f == "S") || (f == "B")) ? 5'd0 : m_instr[11:7];
`ifdef ID_ILLEGAL_TRAP_EN
        ill = (m_mode == 1) && (f == "X");
`else
        ill = 1'b0;
`endif
        chk({tag, ".id_valid"},    32'(bus.id_valid),    32'(ev));
        chk({tag, ".if_ready"},    32'(bus.if_ready),    32'(er));
        chk({tag, ".id_pc"},       bus.id_pc,            m_pc);
        chk({tag, ".id_rs1"},      32'(bus.id_rs1),      32'(m_instr[19:15]));
        chk({tag, ".id_rs2"},      32'(bus.id_rs2),      32'(m_instr[24:20]));
        chk({tag, ".id_rd"},       32'(bus.id_rd),       32'(rd));
        chk({tag, ".id_imm_val"},  32'(bus.id_imm_val),  32'(m_instr[31:7]));
        chk({tag, ".id_imm_type"}, 32'(bus.id_imm_type), 32'(it));
        chk({tag, ".id_illegal"},  32'(bus.id_illegal),  32'(ill));
        @(posedge clk);
        if (bus.flush) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (bus.if_valid && er) begin
                m_mode = 1; m_instr = bus.if_instr; m_pc = bus.if_pc;
            end
        end else if (m_mode == 1) begin
            if (haz) begin
                m_mode = 2;
            end else if (bus.if_valid && er) begin
                m_instr = bus.if_instr; m_pc = bus.if_pc;
            end else if (ev && bus.ex_ready) begin
                m_mode = 0;
            end
        end else begin
            m_mode = 1;
        end
        #1;
    endtask

    logic [6:0] opcs [10];

    initial begin
        opcs = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h7F};
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step("reset");

        // Streaming addi then beq at full rate.
        drive(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); step("stream0");
        drive(1'b1, 32'hFE208EE3, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); step("stream1");
        drive(1'b0, 32'h0,        32'h0,   1'b1, 1'b0, 1'b0, 5'd0, 1'b0); step("stream2");
        step("stream3");

        // Load-use on add x2,x1,x2 with a load to x1 in execute.
        drive(1'b1, 32'h00208133, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); step("lu_cap");
        drive(1'b0, 32'h0,        32'h0,   1'b1, 1'b1, 1'b1, 5'd1, 1'b0); step("lu_haz");
        drive(1'b0, 32'h0,        32'h0,   1'b1, 1'b0, 1'b0, 5'd0, 1'b0); step("lu_bub");
        step("lu_resume");
        step("lu_done");

        // Backpressure for three cycles with a second instruction waiting.
        drive(1'b1, 32'h00A00293, 32'h300, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); step("bp_cap");
        drive(1'b1, 32'h00B00313, 32'h304, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); step("bp0");
        step("bp1");
        step("bp2");
        drive(1'b1, 32'h00B00313, 32'h304, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); step("bp_rel");
        drive(1'b0, 32'h0,        32'h0,   1'b1, 1'b0, 1'b0, 5'd0, 1'b0); step("bp_next");
        step("bp_empty");

        // Flush with a simultaneous offer.
        drive(1'b1, 32'h0000A037, 32'h400, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); step("fl_cap");
        drive(1'b1, 32'h0040006F, 32'h404, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1); step("fl_hit");
        drive(1'b0, 32'h0,        32'h0,   1'b1, 1'b0, 1'b0, 5'd0, 1'b0); step("fl_after");

        // Unrecognised opcode held.
        drive(1'b1, 32'h0000007F, 32'h500, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); step("ill_cap");
        drive(1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b0, 5'd0, 1'b0); step("ill_hold");

        // Reset beats flush and an offer mid-operation.
        drive(1'b1, 32'h00C00393, 32'h600, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        step("midrst");

        // Random traffic with small register indices to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            w        = $urandom;
            w[6:0]   = opcs[$urandom_range(0, 9)];
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), w, $urandom,
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_ctrl.md
ID_STAGE_CTRL -- requirements
Module: id_stage_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 if_valid  in  1  fetch offers an instruction; if_instr  in  32  instruction word; if_pc  in  32  its PC.
REQ-005 if_ready  out  1  decode accepts the offered instruction this cycle.
REQ-006 ex_ready  in  1  execute accepts the decoded instruction; flush  in  1  discard held instruction (branch redirect).
REQ-007 ex_valid  in  1, ex_is_load  in  1, ex_rd  in  5  instruction currently in execute, for load-use detection.
REQ-008 id_valid  out  1; id_pc  out  32; id_rs1, id_rs2, id_rd  out  5 each; id_imm_val  out  25 (= instr[31:7]); id_imm_type  out  3  immediate format select for the sign extender.
REQ-009 id_illegal  out  1  held opcode is not recognised (see Configuration).

Function
REQ-010 States SHALL be EMPTY, FULL, BUBBLE; one instruction register (instr, pc).
REQ-011 Upstream transfer SHALL occur when if_valid && if_ready; downstream transfer when id_valid && ex_ready.
REQ-012 hazard SHALL be: state FULL && ex_valid && ex_is_load && ex_rd != 0 && ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd)); uses_rs1 for R/I/S/B formats, uses_rs2 for R/S/B only.
REQ-013 id_valid SHALL equal (state == FULL) && !hazard; id_* fields SHALL always reflect the held register, combinationally decoded.
REQ-014 if_ready SHALL equal !flush && (state == EMPTY || (state == FULL && ex_ready && !hazard)); no combinational path from if_valid to if_ready.
REQ-015 Transitions: EMPTY->FULL on upstream transfer; FULL->EMPTY on downstream transfer without upstream transfer; FULL->FULL (reload) on simultaneous transfers; FULL->BUBBLE on hazard; BUBBLE->FULL unconditionally next cycle (exactly one bubble, instruction held).
REQ-016 flush SHALL force next state EMPTY from any state, override all transfers, and drop the held instruction; if_valid is ignored that cycle.
REQ-017 id_imm_type SHALL map opcode[6:0]: 0010011/0000011/1100111 -> 000 (I); 0100011 -> 001 (S); 1100011 -> 010 (B); 1101111 -> 011 (J); 0110111/0010111 -> 100 (U); 0110011 (R) and all others -> 111.
REQ-018 id_rd SHALL be forced 0 for S and B formats.
REQ-019 Latency SHALL be one cycle from upstream transfer to id_valid, absent hazard or flush; full throughput of one instruction per cycle.
REQ-020 id_valid SHALL be 0 in EMPTY and BUBBLE regardless of held contents.

Reset
REQ-021 On rst: state EMPTY, instruction register 0, pc 0; thus id_valid 0, if_ready 1, id_imm_type 111, id_illegal 0.
REQ-022 rst asserted mid-operation SHALL discard the held instruction and take priority over flush and all transfers.

Configuration
REQ-023 Macro ID_ILLEGAL_TRAP_EN defined: id_illegal = (state == FULL) && opcode not in the REQ-017/R-type set; instruction still passes downstream.
REQ-024 Macro undefined: id_illegal SHALL be tied 0 and no illegal-detect logic present; port remains.

Structure
REQ-025 Opcode constants, imm_type encodings (IMM_I..IMM_U, IMM_NONE = 111) and the state enum SHALL live in a shared decode package.
REQ-026 Opcode-to-format decode (imm_type, uses_rs1, uses_rs2, illegal) SHALL be a combinational sub-module id_format_decode.

Verification
REQ-027 Reset: rst 1 two cycles, release -> id_valid 0, if_ready 1, id_imm_type 111.
REQ-028 Streaming: if_valid 1 with 0x00500093 (addi x1,x0,5) then 0xFE208EE3 (beq), ex_ready 1 -> id_valid 1 each cycle, imm_type 000 then 010, id_rd 1 then 0.
REQ-029 Load-use: held 0x00208133 (add x2,x1,x2), ex_valid 1, ex_is_load 1, ex_rd 1 -> id_valid 0 for exactly one cycle, if_ready 0, then id_valid 1 same instruction.
REQ-030 Backpressure: FULL, ex_ready 0 for 3 cycles -> id_valid 1 held stable, if_ready 0, no instruction lost or duplicated.
REQ-031 Flush: FULL with simultaneous if_valid 1 and flush 1 -> next cycle EMPTY, id_valid 0, offered instruction not captured.
REQ-032 Illegal (macro defined): held 0x0000007F -> id_illegal 1, imm_type 111; macro undefined -> id_illegal 0.
